// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - default sizing constants and register index type for the register file
// Contents:
//   DEFAULT_DATA_W / DEFAULT_DEPTH / DEFAULT_NUM_RD - default build of the 16-bit CPU register file
//   DEFAULT_ADDR_W                                  - index width derived from DEFAULT_DEPTH
//   reg_idx_t                                       - register index sized from DEFAULT_ADDR_W
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_NUM_RD = 2;
  localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_DEPTH);

  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_rd_mux.sv
// rtl/regfile_rd_mux.sv - DEPTH:1 combinational register select with range check
// Ports:
//   regs     in   DEPTH x DATA_W  flattened storage array, entry i at regs[i]
//   addr     in   ADDR_W          register index to select
//   data     out  DATA_W          selected entry, 0 when addr is out of range
//   in_range out  1               addr < DEPTH
module regfile_rd_mux #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]            addr,
  output logic [DATA_W-1:0]            data,
  output logic                         in_range
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  assign in_range = ({1'b0, addr} < DEPTH_L);

  always_comb begin
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) data = regs[i];
    end
  end

endmodule

// File: rtl/regfile_rdport_array.sv
// rtl/regfile_rdport_array.sv - register file with one write port and NUM_RD registered read ports
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
// Ports:
//   clk      in   1              rising-edge clock
//   rst_n    in   1              asynchronous active-low reset
//   wr_en    in   1              write strobe
//   wr_addr  in   ADDR_W         write register index
//   wr_data  in   DATA_W         write data
//   rd_en    in   NUM_RD         per-port read strobe
//   rd_addr  in   NUM_RD*ADDR_W  port i index at [i*ADDR_W +: ADDR_W]
//   rd_data  out  NUM_RD*DATA_W  port i data at [i*DATA_W +: DATA_W], registered
//   rd_valid out  NUM_RD         port i data updated on the last edge
module regfile_rdport_array
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int NUM_RD  = DEFAULT_NUM_RD,
  parameter int ZERO_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam bit              ZERO_EN = (ZERO_R0 != 0);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;
  logic                         wr_ok;
  logic [ADDR_W-1:0]            rd_idx   [NUM_RD];
  logic [DATA_W-1:0]            mux_data [NUM_RD];
  logic                         mux_ok   [NUM_RD];
  logic [DATA_W-1:0]            sel      [NUM_RD];

  // A write only lands when it targets a real, writable register; the same
  // qualifier gates the bypass so dropped writes never leak to readers.
  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_L) && !(ZERO_EN && wr_addr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    assign rd_idx[g] = rd_addr[g*ADDR_W +: ADDR_W];

    regfile_rd_mux #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_mux (
      .regs     (regs_q),
      .addr     (rd_idx[g]),
      .data     (mux_data[g]),
      .in_range (mux_ok[g])
    );
  end

  // Range and r0 rules win over the bypass.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      sel[p] = mux_data[p];
      if (!mux_ok[p] || (ZERO_EN && rd_idx[p] == '0)) begin
        sel[p] = '0;
      end else if (BYPASS && wr_ok && rd_idx[p] == wr_addr) begin
        sel[p] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        rd_valid[p] <= rd_en[p];
        if (rd_en[p]) rd_data[p*DATA_W +: DATA_W] <= sel[p];
      end
    end
  end

endmodule

// File: doc/regfile_rdport_array.md
# regfile_rdport_array

Parametrised general-purpose register file for the 16-bit CPU, generalising the single 16:1 rs2 select into a clocked storage array. It has one synchronous write port and NUM_RD independent registered read ports (rs1, rs2, ...), with optional same-cycle write-to-read bypass. It sits between decode (register addresses) and execute (operands), replacing the combinational per-operand muxes.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- DEPTH, 16, number of architectural registers (power of two not required)
- ADDR_W, $clog2(DEPTH), register address width
- NUM_RD, 2, number of read ports (>=1)
- ZERO_R0, 1, 1 = register 0 reads as zero and ignores writes

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write register index
- wr_data  in  DATA_W  write data
- rd_en  in  NUM_RD  per-port read strobe
- rd_addr  in  NUM_RD*ADDR_W  port i index at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  port i data at [i*DATA_W +: DATA_W], registered
- rd_valid  out  NUM_RD  port i data updated on the last edge

## Operation
- Write: at rising clk with wr_en=1, reg[wr_addr] <= wr_data. Dropped if wr_addr >= DEPTH, or if ZERO_R0=1 and wr_addr=0.
- Read: at rising clk with rd_en[i]=1, rd_data[i] <= selected value; rd_valid[i] <= rd_en[i] every cycle.
- rd_en[i]=0: rd_data[i] holds its previous value; rd_valid[i] goes 0.
- Selected value: 0 if rd_addr[i] >= DEPTH; 0 if ZERO_R0=1 and rd_addr[i]=0; otherwise bypass value (see Configuration) or reg[rd_addr[i]].
- All read ports are independent; any number may address the same register in the same cycle and receive identical data.
- No state machine: storage array plus one output register stage per port.

## Timing
- Read latency: exactly 1 cycle (address/strobe at edge N -> data/valid visible after edge N).
- Write visible to a read issued in a later cycle; same-cycle behaviour per Configuration.
- Reset (rst_n=0, asynchronous, any time including mid-read/write): all registers 0, rd_data all 0, rd_valid all 0. The write in the edge coincident with reset assertion is lost. The first edge after deassertion operates normally.

## Configuration
- REGFILE_BYPASS_EN defined: a read with rd_en[i]=1 and rd_addr[i]=wr_addr in a cycle with a valid (non-dropped) write returns wr_data.
- REGFILE_BYPASS_EN not defined: that read returns the register's pre-write value. The new value is visible from the next read cycle.
- ZERO_R0 and range rules take precedence over bypass in both builds.

## Structure
- Package regfile_pkg: default DATA_W/DEPTH/NUM_RD constants and a reg-index typedef sized from default ADDR_W.
- Sub-module regfile_rd_mux: parametrised DEPTH:1 combinational select (DATA_W, DEPTH) with range check. Instantiated NUM_RD times in a generate loop; bypass and ZERO_R0 logic live in the top.

## Test plan
- Reset then read all 16 regs on 2 ports -> rd_data=0x0000 and rd_valid=1 one cycle after each rd_en.
- Write r5=0xBEEF, next cycle read r5 on port0 and port1 -> both 0xBEEF after one edge.
- Write r3=0x1234, then same cycle write r3=0xAAAA and read r3 -> 0xAAAA with REGFILE_BYPASS_EN, 0x1234 without.
- ZERO_R0=1: write r0=0xFFFF, read r0 with the write and in the next cycle -> 0x0000 both times. Repeat with DEPTH=12 and an address of 13 -> write dropped, read 0x0000.
- rd_en low after read of 0x5A5A -> rd_data holds 0x5A5A and rd_valid=0. A later write to that register does not change rd_data.
- Assert rst_n low mid-cycle after writing r7=0x00FF -> outputs 0 immediately. After release, read r7 -> 0x0000.
